// File: rtl/cpu_pkg.sv
// Shared constants for the CPU datapath bit selector.
package cpu_pkg;

    localparam int SEL_DATA_W = 4;

    localparam logic [1:0] SEL_BIT0 = 2'd0;
    localparam logic [1:0] SEL_BIT1 = 2'd1;
    localparam logic [1:0] SEL_BIT2 = 2'd2;
    localparam logic [1:0] SEL_BIT3 = 2'd3;

endpackage

// File: rtl/cpu_selector_if.sv
// Bus between the datapath and the dual 4:1 bit selector.
interface cpu_selector_if;
    import cpu_pkg::*;

    logic                  s0;
    logic                  s1;
    logic [SEL_DATA_W-1:0] in1;
    logic [SEL_DATA_W-1:0] in2;
    logic                  out1;
    logic                  out2;
    logic                  out1_q;
    logic                  out2_q;

    modport master (
        output s0, s1, in1, in2,
        input  out1, out2, out1_q, out2_q
    );

    modport slave (
        input  s0, s1, in1, in2,
        output out1, out2, out1_q, out2_q
    );

endinterface

// File: rtl/mux4_bit.sv
// Combinational 4:1 single-bit selector; an unknown select yields X.
module mux4_bit
    import cpu_pkg::*;
(
    input  logic [SEL_DATA_W-1:0] data,
    input  logic [1:0]            sel,
    output logic                  y
);

    always_comb begin
        y = 1'bx;
        case (sel)
            SEL_BIT0: y = data[0];
            SEL_BIT1: y = data[1];
            SEL_BIT2: y = data[2];
            SEL_BIT3: y = data[3];
            default:  y = 1'bx;
        endcase
    end

endmodule

// File: rtl/cpu_selector.sv
// Dual 4:1 bit selector with combinational and registered copies of each result.
module cpu_selector
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    cpu_selector_if.slave  bus
);

    logic [1:0] sel;
    logic       sel1;
    logic       sel2;
    logic       sel1_q;
    logic       sel2_q;

    assign sel = {bus.s1, bus.s0};

    mux4_bit u_mux_ch1 (
        .data (bus.in1),
        .sel  (sel),
        .y    (sel1)
    );

    mux4_bit u_mux_ch2 (
        .data (bus.in2),
        .sel  (sel),
        .y    (sel2)
    );

    // Registered copies clear asynchronously; the combinational path ignores reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel1_q <= 1'b0;
            sel2_q <= 1'b0;
        end else begin
            sel1_q <= sel1;
            sel2_q <= sel2;
        end
    end

    assign bus.out1   = sel1;
    assign bus.out2   = sel2;
    assign bus.out1_q = sel1_q;
    assign bus.out2_q = sel2_q;

endmodule

// File: tb/tb_cpu_selector.sv
// Directed and randomized bench for cpu_selector against a shift-based reference model.
module tb_cpu_selector;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    cpu_selector_if bus ();

    cpu_selector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the chosen bit is what lands in bit 0 after shifting right by the select value.
    function automatic logic ref_bit(input logic [3:0] v, input int s);
        logic [3:0] shifted;
        shifted = v >> s;
        return (shifted % 2) == 1;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input int s);
        bus.in1 = a;
        bus.in2 = b;
        bus.s1  = (s >= 2);
        bus.s0  = (s % 2) == 1;
    endtask

    initial begin
        logic [3:0] a;
        logic [3:0] b;
        int         s;
        logic       exp1_q;
        logic       exp2_q;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(4'b1010, 4'b1100, 0);

        // Reset state with clocks running
        repeat (2) @(posedge clk);
        #1;
        check("reset_out1_q", bus.out1_q, 1'b0);
        check("reset_out2_q", bus.out2_q, 1'b0);

        // Static data, select sweep (combinational, still under reset)
        for (int i = 0; i < 4; i++) begin
            drive(4'b1010, 4'b1100, i);
            #1;
            check($sformatf("sweep_out1_sel%0d", i), bus.out1, (i == 1 || i == 3));
            check($sformatf("sweep_out2_sel%0d", i), bus.out2, (i >= 2));
        end
        check("sweep_out1_q_in_reset", bus.out1_q, 1'b0);

        // Hold select 3, change data with no clock dependency
        @(negedge clk);
        drive(4'b1010, 4'b1100, 3);
        #1 check("hold_in1_1010", bus.out1, 1'b1);
        drive(4'b0111, 4'b1100, 3);
        #1 check("hold_in1_0111", bus.out1, 1'b0);
        drive(4'b1000, 4'b1100, 3);
        #1 check("hold_in1_1000", bus.out1, 1'b1);

        // Registered path with mid-cycle select change
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1010, 4'b1100, 1);
        @(posedge clk);
        #1 check("reg_sel01_out1_q", bus.out1_q, 1'b1);
        @(negedge clk);
        drive(4'b1010, 4'b1100, 0);
        #1;
        check("reg_midcycle_out1", bus.out1, 1'b0);
        check("reg_midcycle_out1_q", bus.out1_q, 1'b1);
        @(posedge clk);
        #1 check("reg_next_edge_out1_q", bus.out1_q, 1'b0);

        // Asynchronous reset between edges
        @(negedge clk);
        drive(4'b1111, 4'b1111, 2);
        @(posedge clk);
        #1;
        check("pre_reset_out1_q", bus.out1_q, 1'b1);
        check("pre_reset_out2_q", bus.out2_q, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out1_q", bus.out1_q, 1'b0);
        check("async_out2_q", bus.out2_q, 1'b0);
        check("async_out1", bus.out1, 1'b1);
        check("async_out2", bus.out2, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("release_before_edge_out1_q", bus.out1_q, 1'b0);
        @(posedge clk);
        #1;
        check("release_first_edge_out1_q", bus.out1_q, 1'b1);
        check("release_first_edge_out2_q", bus.out2_q, 1'b1);

        // Exhaustive: every in1/in2 pair over every select code
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int is = 0; is < 4; is++) begin
                    a = 4'(ia);
                    b = 4'(ib);
                    @(negedge clk);
                    drive(a, b, is);
                    #1;
                    check("exh_out1", bus.out1, ref_bit(a, is));
                    check("exh_out2", bus.out2, ref_bit(b, is));
                    @(posedge clk);
                    #1;
                    check("exh_out1_q", bus.out1_q, ref_bit(a, is));
                    check("exh_out2_q", bus.out2_q, ref_bit(b, is));
                end
            end
        end

        // Randomized back-to-back traffic, inputs changing every cycle
        exp1_q = bus.out1_q;
        exp2_q = bus.out2_q;
        for (int n = 0; n < 300; n++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            s = int'($urandom_range(0, 3));
            @(negedge clk);
            check("rnd_hold_out1_q", bus.out1_q, exp1_q);
            check("rnd_hold_out2_q", bus.out2_q, exp2_q);
            drive(a, b, s);
            #1;
            check("rnd_out1", bus.out1, ref_bit(a, s));
            check("rnd_out2", bus.out2, ref_bit(b, s));
            exp1_q = ref_bit(a, s);
            exp2_q = ref_bit(b, s);
            @(posedge clk);
            #1;
            check("rnd_out1_q", bus.out1_q, exp1_q);
            check("rnd_out2_q", bus.out2_q, exp2_q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
